// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: drives a req/ack data bus with byte enables,
// lane-aligns store and load data, flags illegal/misaligned accesses and
// turns bus errors or timeouts into access faults. Stalls upstream while
// a bus transaction is outstanding.
module lsu_mem_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [4:0]          in_mem_command,
  input  logic [4:0]          in_reg_d,
  input  logic [XLEN-1:0]     in_alu_out,
  input  logic [XLEN-1:0]     in_mem_write_data,
  input  logic [XLEN-1:0]     in_now_pc,
  output logic                stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [XLEN-1:0]     bus_rdata,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_wb_data,
  output logic [4:0]          out_reg_d,
  output logic [XLEN-1:0]     out_now_pc,
  output logic                out_exc,
  output logic [3:0]          out_exc_cause,
  output logic [XLEN-1:0]     out_exc_tval
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFS  = $clog2(NB);
  localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned MinW = (ADDR_W < XLEN) ? ADDR_W : XLEN;

  localparam logic [3:0] CauseIllegal  = 4'd2;
  localparam logic [3:0] CauseLdAlign  = 4'd4;
  localparam logic [3:0] CauseLdFault  = 4'd5;
  localparam logic [3:0] CauseStAlign  = 4'd6;
  localparam logic [3:0] CauseStFault  = 4'd7;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Command captured at issue, used while waiting on the bus
  logic              is_st_q, is_st_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFS-1:0]    off_q, off_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   pc_q, pc_d;

  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]     bus_be_q, bus_be_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_wb_data_q, out_wb_data_d;
  logic [4:0]        out_reg_d_q, out_reg_d_d;
  logic [XLEN-1:0]   out_now_pc_q, out_now_pc_d;
  logic              out_exc_q, out_exc_d;
  logic [3:0]        out_cause_q, out_cause_d;
  logic [XLEN-1:0]   out_tval_q, out_tval_d;

  logic              is_access, is_wr;
  logic [2:0]        f3;
  logic [OFS-1:0]    in_off;
  logic              legal, aligned, timeout, fault;
  logic [NB-1:0]     sz_mask, be_new;
  logic [XLEN-1:0]   wdata_new;
  logic [ADDR_W-1:0] addr_new;
  logic [XLEN-1:0]   rd_sh, ld_mask, load_data;
  logic              ld_sign;

  assign is_access = in_mem_command[0];
  assign is_wr     = in_mem_command[1];
  assign f3        = in_mem_command[4:2];
  assign in_off    = in_alu_out[OFS-1:0];

  // Legal funct3 encodings; doubleword forms exist only on a 64-bit datapath
  always_comb begin
    legal = 1'b0;
    if (is_wr) begin
      case (f3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (XLEN == 64);
        default:                                legal = 1'b0;
      endcase
    end
  end

  // Natural alignment check on the byte offset within the bus word
  always_comb begin
    case (f3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~in_off[0];
      2'd2:    aligned = ~|in_off[1:0];
      default: aligned = ~|in_off;
    endcase
  end

  // Store lane placement: enables and data shifted to the addressed byte
  always_comb begin
    case (f3[1:0])
      2'd0:    sz_mask = NB'(8'h01);
      2'd1:    sz_mask = NB'(8'h03);
      2'd2:    sz_mask = NB'(8'h0F);
      default: sz_mask = NB'(8'hFF);
    endcase
    be_new    = sz_mask << in_off;
    wdata_new = in_mem_write_data << {in_off, 3'b000};
  end

  // Word-aligned bus address, zero-extended or truncated to ADDR_W
  always_comb begin
    addr_new = '0;
    for (int i = int'(OFS); i < int'(MinW); i++) begin
      addr_new[i] = in_alu_out[i];
    end
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend
  always_comb begin
    rd_sh = bus_rdata >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'd0: begin
        ld_mask = XLEN'(64'hFF);
        ld_sign = rd_sh[7];
      end
      2'd1: begin
        ld_mask = XLEN'(64'hFFFF);
        ld_sign = rd_sh[15];
      end
      2'd2: begin
        ld_mask = XLEN'(64'hFFFF_FFFF);
        ld_sign = rd_sh[31];
      end
      default: begin
        ld_mask = '1;
        ld_sign = 1'b0;
      end
    endcase
    ld_sign   = ld_sign & ~f3_q[2];
    load_data = (rd_sh & ld_mask) | (ld_sign ? ~ld_mask : '0);
  end

  assign timeout = (state_q == StWait) && (TIMEOUT_CYC != 0) &&
                   (cnt_q == CntW'(TIMEOUT_CYC));
  assign fault   = bus_err | timeout;

  assign stall = ((state_q == StIdle) & in_valid & is_access & legal & aligned) |
                 ((state_q == StWait) & ~bus_ack & ~bus_err & ~timeout);

  // Next-state logic for the FSM, bus outputs and retirement registers
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_st_d       = is_st_q;
    f3_d          = f3_q;
    off_d         = off_q;
    addr_d        = addr_q;
    rd_d          = rd_q;
    pc_d          = pc_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    out_valid_d   = 1'b0;
    out_wb_data_d = out_wb_data_q;
    out_reg_d_d   = out_reg_d_q;
    out_now_pc_d  = out_now_pc_q;
    out_exc_d     = out_exc_q;
    out_cause_d   = out_cause_q;
    out_tval_d    = out_tval_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_access) begin
            out_valid_d   = 1'b1;
            out_wb_data_d = in_alu_out;
            out_reg_d_d   = in_reg_d;
            out_now_pc_d  = in_now_pc;
            out_exc_d     = 1'b0;
            out_cause_d   = '0;
            out_tval_d    = '0;
          end else begin
            is_st_d = is_wr;
            f3_d    = f3;
            off_d   = in_off;
            addr_d  = in_alu_out;
            rd_d    = in_reg_d;
            pc_d    = in_now_pc;
            if (!legal || !aligned) begin
              out_valid_d   = 1'b1;
              out_wb_data_d = '0;
              out_reg_d_d   = in_reg_d;
              out_now_pc_d  = in_now_pc;
              out_exc_d     = 1'b1;
              if (!legal) begin
                out_cause_d = CauseIllegal;
                out_tval_d  = '0;
              end else begin
                out_cause_d = is_wr ? CauseStAlign : CauseLdAlign;
                out_tval_d  = in_alu_out;
              end
            end else begin
              state_d     = StWait;
              cnt_d       = '0;
              bus_req_d   = 1'b1;
              bus_we_d    = is_wr;
              bus_addr_d  = addr_new;
              bus_be_d    = is_wr ? be_new : '0;
              bus_wdata_d = is_wr ? wdata_new : '0;
            end
          end
        end
      end
      StWait: begin
        if (fault || bus_ack) begin
          state_d      = StIdle;
          cnt_d        = '0;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_addr_d   = '0;
          bus_be_d     = '0;
          bus_wdata_d  = '0;
          out_valid_d  = 1'b1;
          out_reg_d_d  = rd_q;
          out_now_pc_d = pc_q;
          if (fault) begin
            out_wb_data_d = '0;
            out_exc_d     = 1'b1;
            out_cause_d   = is_st_q ? CauseStFault : CauseLdFault;
            out_tval_d    = addr_q;
          end else begin
            out_wb_data_d = is_st_q ? addr_q : load_data;
            out_exc_d     = 1'b0;
            out_cause_d   = '0;
            out_tval_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      is_st_q       <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      addr_q        <= '0;
      rd_q          <= '0;
      pc_q          <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      out_valid_q   <= 1'b0;
      out_wb_data_q <= '0;
      out_reg_d_q   <= '0;
      out_now_pc_q  <= '0;
      out_exc_q     <= 1'b0;
      out_cause_q   <= '0;
      out_tval_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_st_q       <= is_st_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      addr_q        <= addr_d;
      rd_q          <= rd_d;
      pc_q          <= pc_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      out_valid_q   <= out_valid_d;
      out_wb_data_q <= out_wb_data_d;
      out_reg_d_q   <= out_reg_d_d;
      out_now_pc_q  <= out_now_pc_d;
      out_exc_q     <= out_exc_d;
      out_cause_q   <= out_cause_d;
      out_tval_q    <= out_tval_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign out_valid     = out_valid_q;
  assign out_wb_data   = out_wb_data_q;
  assign out_reg_d     = out_reg_d_q;
  assign out_now_pc    = out_now_pc_q;
  assign out_exc       = out_exc_q;
  assign out_exc_cause = out_cause_q;
  assign out_exc_tval  = out_tval_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a 32-bit instance with a short timeout
// and a 64-bit instance for doubleword/word-extension loads.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // 32-bit instance
  logic        in_valid;
  logic [4:0]  in_cmd, in_rd;
  logic [31:0] in_alu, in_wd, in_pc;
  logic        stall, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        out_valid, out_exc;
  logic [31:0] out_wb, out_pc, out_tval;
  logic [4:0]  out_rd;
  logic [3:0]  out_cause;

  // 64-bit instance
  logic        in_valid64;
  logic [4:0]  in_cmd64;
  logic [63:0] in_alu64, in_wd64, in_pc64;
  logic        stall64, bus_req64, bus_we64, bus_ack64, bus_err64;
  logic [31:0] bus_addr64;
  logic [7:0]  bus_be64;
  logic [63:0] bus_wdata64, bus_rdata64;
  logic        out_valid64, out_exc64;
  logic [63:0] out_wb64, out_pc64, out_tval64;
  logic [4:0]  out_rd64;
  logic [3:0]  out_cause64;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mem_command(in_cmd),
    .in_reg_d(in_rd), .in_alu_out(in_alu), .in_mem_write_data(in_wd), .in_now_pc(in_pc),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .out_valid(out_valid), .out_wb_data(out_wb),
    .out_reg_d(out_rd), .out_now_pc(out_pc), .out_exc(out_exc),
    .out_exc_cause(out_cause), .out_exc_tval(out_tval)
  );

  lsu_mem_stage #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_mem_command(in_cmd64),
    .in_reg_d(5'd9), .in_alu_out(in_alu64), .in_mem_write_data(in_wd64),
    .in_now_pc(in_pc64), .stall(stall64), .bus_req(bus_req64), .bus_we(bus_we64),
    .bus_addr(bus_addr64), .bus_be(bus_be64), .bus_wdata(bus_wdata64),
    .bus_ack(bus_ack64), .bus_err(bus_err64), .bus_rdata(bus_rdata64),
    .out_valid(out_valid64), .out_wb_data(out_wb64), .out_reg_d(out_rd64),
    .out_now_pc(out_pc64), .out_exc(out_exc64), .out_exc_cause(out_cause64),
    .out_exc_tval(out_tval64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] cmd, input logic [31:0] alu, input logic [31:0] wd);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_alu   = alu;
    in_wd    = wd;
    in_rd    = 5'd7;
    in_pc    = 32'h0000_0400;
  endtask

  initial begin
    in_valid = 0; in_cmd = 0; in_rd = 0; in_alu = 0; in_wd = 0; in_pc = 0;
    bus_ack = 0; bus_err = 0; bus_rdata = 0;
    in_valid64 = 0; in_cmd64 = 0; in_alu64 = 0; in_wd64 = 0; in_pc64 = 0;
    bus_ack64 = 0; bus_err64 = 0; bus_rdata64 = 0;

    // Reset state
    cyc(); cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wb", 64'(out_wb), 64'd0);
    chk("rst_exc", 64'(out_exc), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Pass-through
    in_valid = 1; in_cmd = 5'b00000; in_alu = 32'h1234; in_rd = 5'd5; in_pc = 32'h100;
    #1 chk("pt_stall", 64'(stall), 64'd0);
    cyc();
    in_valid = 0;
    chk("pt_valid", 64'(out_valid), 64'd1);
    chk("pt_wb", 64'(out_wb), 64'h1234);
    chk("pt_rd", 64'(out_rd), 64'd5);
    chk("pt_pc", 64'(out_pc), 64'h100);
    chk("pt_busreq", 64'(bus_req), 64'd0);
    cyc();
    chk("pt_valid_pulse", 64'(out_valid), 64'd0);
    chk("pt_wb_hold", 64'(out_wb), 64'h1234);

    // LB at 0x1003, three ack-less wait cycles
    issue(5'b00001, 32'h1003, 32'h0);
    #1 chk("lb_stall_issue", 64'(stall), 64'd1);
    cyc();
    in_valid = 0;
    chk("lb_req", 64'(bus_req), 64'd1);
    chk("lb_addr", 64'(bus_addr), 64'h1000);
    chk("lb_be", 64'(bus_be), 64'h0);
    chk("lb_we", 64'(bus_we), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall_wait", 64'(stall), 64'd1);
      chk("lb_no_valid", 64'(out_valid), 64'd0);
      cyc();
    end
    bus_ack = 1; bus_rdata = 32'h80FF_FFFF;
    #1 chk("lb_stall_ack", 64'(stall), 64'd0);
    cyc();
    bus_ack = 0;
    chk("lb_valid", 64'(out_valid), 64'd1);
    chk("lb_wb", 64'(out_wb), 64'hFFFF_FF80);
    chk("lb_exc", 64'(out_exc), 64'd0);
    chk("lb_req_drop", 64'(bus_req), 64'd0);

    // SH at 0x2002, immediate ack
    issue(5'b00111, 32'h2002, 32'h0000_ABCD);
    cyc();
    in_valid = 0;
    chk("sh_be", 64'(bus_be), 64'hC);
    chk("sh_wdata", 64'(bus_wdata), 64'hABCD_0000);
    chk("sh_we", 64'(bus_we), 64'd1);
    chk("sh_addr", 64'(bus_addr), 64'h2000);
    bus_ack = 1;
    cyc();
    bus_ack = 0;
    chk("sh_valid", 64'(out_valid), 64'd1);
    chk("sh_wb", 64'(out_wb), 64'h2002);
    chk("sh_req_drop", 64'(bus_req), 64'd0);

    // Misaligned LW at 0x3001
    issue(5'b01001, 32'h3001, 32'h0);
    #1 chk("lwmis_stall", 64'(stall), 64'd0);
    cyc();
    in_valid = 0;
    chk("lwmis_valid", 64'(out_valid), 64'd1);
    chk("lwmis_exc", 64'(out_exc), 64'd1);
    chk("lwmis_cause", 64'(out_cause), 64'd4);
    chk("lwmis_tval", 64'(out_tval), 64'h3001);
    chk("lwmis_req", 64'(bus_req), 64'd0);
    cyc();
    chk("lwmis_req2", 64'(bus_req), 64'd0);

    // Unsupported: LWU on a 32-bit datapath
    issue(5'b11001, 32'h3100, 32'h0);
    cyc();
    in_valid = 0;
    chk("ill_cause", 64'(out_cause), 64'd2);
    chk("ill_tval", 64'(out_tval), 64'd0);
    chk("ill_req", 64'(bus_req), 64'd0);

    // SW never acknowledged: timeout fires in the fifth wait cycle
    issue(5'b01011, 32'h4000, 32'h55);
    cyc();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("sw_req_wait", 64'(bus_req), 64'd1);
      chk("sw_stall_wait", 64'(stall), 64'd1);
      cyc();
    end
    chk("sw_req_last", 64'(bus_req), 64'd1);
    chk("sw_stall_to", 64'(stall), 64'd0);
    cyc();
    chk("sw_req_drop", 64'(bus_req), 64'd0);
    chk("sw_valid", 64'(out_valid), 64'd1);
    chk("sw_exc", 64'(out_exc), 64'd1);
    chk("sw_cause", 64'(out_cause), 64'd7);
    chk("sw_tval", 64'(out_tval), 64'h4000);
    bus_ack = 1;
    cyc();
    bus_ack = 0;
    chk("stray_valid", 64'(out_valid), 64'd0);
    chk("stray_req", 64'(bus_req), 64'd0);

    // LBU with err and ack together: error wins
    issue(5'b10001, 32'h7001, 32'h0);
    cyc();
    in_valid = 0;
    bus_err = 1; bus_ack = 1;
    cyc();
    bus_err = 0; bus_ack = 0;
    chk("err_valid", 64'(out_valid), 64'd1);
    chk("err_cause", 64'(out_cause), 64'd5);
    chk("err_tval", 64'(out_tval), 64'h7001);

    // LHU interrupted by reset mid-WAIT
    issue(5'b10101, 32'h5002, 32'h0);
    cyc();
    in_valid = 0;
    chk("lhu_req", 64'(bus_req), 64'd1);
    rst_n = 0;
    #1;
    chk("rstw_req", 64'(bus_req), 64'd0);
    chk("rstw_addr", 64'(bus_addr), 64'd0);
    chk("rstw_exc", 64'(out_exc), 64'd0);
    chk("rstw_cause", 64'(out_cause), 64'd0);
    chk("rstw_tval", 64'(out_tval), 64'd0);
    @(negedge clk) rst_n = 1;
    cyc();
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    cyc();
    bus_ack = 0;
    chk("rstw_stray", 64'(out_valid), 64'd0);

    // LW completing normally after reset
    issue(5'b01001, 32'h6004, 32'h0);
    cyc();
    in_valid = 0;
    chk("lw_addr", 64'(bus_addr), 64'h6004);
    bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    cyc();
    bus_ack = 0;
    chk("lw_valid", 64'(out_valid), 64'd1);
    chk("lw_wb", 64'(out_wb), 64'hDEAD_BEEF);

    // 64-bit LD at 0x8
    in_valid64 = 1; in_cmd64 = 5'b01101; in_alu64 = 64'h8; in_pc64 = 64'h200;
    cyc();
    in_valid64 = 0;
    chk("ld_addr", 64'(bus_addr64), 64'h8);
    chk("ld_be", 64'(bus_be64), 64'h0);
    bus_ack64 = 1; bus_rdata64 = 64'h0123_4567_89AB_CDEF;
    cyc();
    bus_ack64 = 0;
    chk("ld_valid", 64'(out_valid64), 64'd1);
    chk("ld_wb", out_wb64, 64'h0123_4567_89AB_CDEF);

    // 64-bit LW at 0xC: upper word lane, sign-extended
    in_valid64 = 1; in_cmd64 = 5'b01001; in_alu64 = 64'hC;
    cyc();
    in_valid64 = 0;
    chk("lw64_addr", 64'(bus_addr64), 64'h8);
    bus_ack64 = 1; bus_rdata64 = 64'h8000_0000_0000_0000;
    cyc();
    bus_ack64 = 0;
    chk("lw64_wb", out_wb64, 64'hFFFF_FFFF_8000_0000);

    // 64-bit SB at 0x5: enable and data on lane 5
    in_valid64 = 1; in_cmd64 = 5'b00011; in_alu64 = 64'h5; in_wd64 = 64'hA5;
    cyc();
    in_valid64 = 0;
    chk("sb64_be", 64'(bus_be64), 64'h20);
    chk("sb64_wdata", bus_wdata64, 64'h0000_A500_0000_0000);
    bus_ack64 = 1;
    cyc();
    bus_ack64 = 0;
    chk("sb64_wb", out_wb64, 64'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
